// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM states, funct3 load/store widths and default timeout for the MEM-stage controller.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int TIMEOUT_CYCLES_DEF = 64;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-enable/store-lane generation, misalignment detect and load extraction/extension.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  req_f3_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] req_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);
  logic req_b, req_h;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign req_b = (req_f3_i == F3_B) || (req_f3_i == F3_BU);
  assign req_h = (req_f3_i == F3_H) || (req_f3_i == F3_HU);
  assign be_o = req_b ? (4'b0001 << req_off_i) : req_h ? (req_off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // Replicating the operand places it in whichever lane the byte enables select.
  assign wdata_o = req_b ? {4{req_data_i[7:0]}} : req_h ? {2{req_data_i[15:0]}} : req_data_i;
  assign misalign_o = req_b ? 1'b0 : req_h ? req_off_i[0] : |req_off_i;
  assign byte_v = ld_word_i[8*ld_off_i +: 8];
  assign half_v = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
  assign ld_data_o = (ld_f3_i == F3_B)  ? {{24{byte_v[7]}}, byte_v} :
                     (ld_f3_i == F3_BU) ? {24'h0, byte_v} :
                     (ld_f3_i == F3_H)  ? {{16{half_v[15]}}, half_v} :
                     (ld_f3_i == F3_HU) ? {16'h0, half_v} : ld_word_i;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage request/ready controller that stalls the front pipeline during data accesses.
// Define MEM_TIMEOUT_EN to abort requests that see no ready within TIMEOUT_CYCLES REQ cycles.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RDData_i,
  input  logic [31:0] instr_i,
  output logic        Stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        err_o
);
  state_e state_q, state_d;
  logic access, mis_c, to;
  logic we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, wdata_c, ld_c;
  logic [3:0] be_q, be_d, be_c;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic rvalid_q, rvalid_d, mis_q, mis_d, err_q, err_d;
  logic unused_instr;
  assign unused_instr = ^{instr_i[31:15], instr_i[11:0]};
  assign access = MemRead_i | MemWrite_i;

  mem_lane_align u_align (
    .req_f3_i   (instr_i[14:12]),
    .req_off_i  (ALUResult_i[1:0]),
    .req_data_i (RDData_i),
    .be_o       (be_c),
    .wdata_o    (wdata_c),
    .misalign_o (mis_c),
    .ld_f3_i    (f3_q),
    .ld_off_i   (off_q),
    .ld_word_i  (mem_rdata_i),
    .ld_data_o  (ld_c)
  );

`ifdef MEM_TIMEOUT_EN
  logic [15:0] cnt_q;
  assign to = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  // Held at zero outside REQ, so it is already clear on entry to REQ.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= (state_q == REQ) ? cnt_q + 16'd1 : '0;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign to = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    f3_d     = f3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    mis_d    = 1'b0;
    err_d    = 1'b0;
    if (state_q == IDLE && access) begin
      state_d = mis_c ? DONE : REQ;
      mis_d   = mis_c;
      if (mis_c) rdata_d = MemWrite_i ? rdata_q : '0;
      else begin
        we_d    = MemWrite_i;
        addr_d  = {ALUResult_i[31:2], 2'b00};
        wdata_d = wdata_c;
        be_d    = be_c;
        f3_d    = instr_i[14:12];
        off_d   = ALUResult_i[1:0];
      end
    end else if (state_q == REQ) begin
      if (mem_ready_i) begin
        state_d  = DONE;
        rdata_d  = we_q ? rdata_q : ld_c;
        rvalid_d = !we_q;
      end else if (to) begin
        state_d = DONE;
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end else if (state_q == DONE) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      f3_q     <= '0;
      off_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
    end
  end

  assign Stall_o       = (state_q == REQ) || (state_q == IDLE && access);
  assign mem_req_o     = (state_q == REQ);
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_be_o      = be_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign misalign_o    = mis_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven directed vectors plus reset-mid-request and optional timeout sequences.
module tb_mem_access_ctrl;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic MemRead_i = 1'b0, MemWrite_i = 1'b0, mem_ready_i = 1'b0;
  logic [31:0] ALUResult_i = '0, RDData_i = '0, instr_i = '0, mem_rdata_i = '0;
  logic Stall_o, mem_req_o, mem_we_o, rdata_valid_o, misalign_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;
  logic [3:0] mem_be_o;
  int total = 0, bad = 0;

  always #5 clk_i = ~clk_i;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .ALUResult_i(ALUResult_i), .RDData_i(RDData_i), .instr_i(instr_i), .Stall_o(Stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i), .rdata_o(rdata_o),
    .rdata_valid_o(rdata_valid_o), .misalign_o(misalign_o), .err_o(err_o)
  );

  typedef struct {
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] addr, wd, rdw;
    int lat, stalls;
    logic [31:0] eaddr;
    logic [3:0] ebe;
    logic ewe;
    logic [31:0] ewd, erd;
    logic evalid, emis, eerr;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int stalls = 0;
    int reqs = 0;
    bit done = 0;
    @(negedge clk_i);
    MemRead_i = v.rd; MemWrite_i = v.wr; ALUResult_i = v.addr; RDData_i = v.wd;
    instr_i = {17'h0, v.f3, 12'h003}; mem_rdata_i = v.rdw; mem_ready_i = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!Stall_o) done = 1;
      else begin
        stalls++;
        if (mem_req_o) begin
          reqs++;
          if (reqs == 1) begin
            chk($sformatf("v%0d addr", idx), mem_addr_o, v.eaddr);
            chk($sformatf("v%0d be", idx), {28'h0, mem_be_o}, {28'h0, v.ebe});
            chk($sformatf("v%0d we", idx), {31'h0, mem_we_o}, {31'h0, v.ewe});
            if (v.ewe) chk($sformatf("v%0d wdata", idx), mem_wdata_o, v.ewd);
          end
          mem_ready_i = (reqs == v.lat);
        end
        @(negedge clk_i);
      end
    end
    chk($sformatf("v%0d done", idx), {31'h0, done}, 32'd1);
    chk($sformatf("v%0d stalls", idx), stalls, v.stalls);
    chk($sformatf("v%0d req_low", idx), {31'h0, mem_req_o}, 32'd0);
    chk($sformatf("v%0d rdata", idx), rdata_o, v.erd);
    chk($sformatf("v%0d valid", idx), {31'h0, rdata_valid_o}, {31'h0, v.evalid});
    chk($sformatf("v%0d misalign", idx), {31'h0, misalign_o}, {31'h0, v.emis});
    chk($sformatf("v%0d err", idx), {31'h0, err_o}, {31'h0, v.eerr});
    MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  vec_t vecs[14];
  vec_t tv;

  initial begin
    //           rd  wr  f3      addr          wd            rdw           lat st eaddr         ebe     ewe  ewd           erd           val  mis  err
    vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        32'h12345678, 3, 4, 32'h100, 4'b1111, 0, 32'h0,        32'h12345678, 1, 0, 0};
    vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 1, 2, 32'h100, 4'b1000, 0, 32'h0,        32'hFFFFFF80, 1, 0, 0};
    vecs[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 1, 2, 32'h100, 4'b1000, 0, 32'h0,        32'h00000080, 1, 0, 0};
    vecs[3]  = '{0, 1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0,        1, 2, 32'h200, 4'b1100, 1, 32'hBEEFBEEF, 32'h00000080, 0, 0, 0};
    vecs[4]  = '{1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        1, 1, 32'h0,   4'b0000, 0, 32'h0,        32'h00000000, 0, 1, 0};
    vecs[5]  = '{0, 0, 3'b010, 32'h100, 32'h0,        32'h0,        1, 0, 32'h0,   4'b0000, 0, 32'h0,        32'h00000000, 0, 0, 0};
    vecs[6]  = '{1, 0, 3'b001, 32'h106, 32'h0,        32'h80011234, 2, 3, 32'h104, 4'b1100, 0, 32'h0,        32'hFFFF8001, 1, 0, 0};
    vecs[7]  = '{1, 0, 3'b101, 32'h104, 32'h0,        32'h80019234, 1, 2, 32'h104, 4'b0011, 0, 32'h0,        32'h00009234, 1, 0, 0};
    vecs[8]  = '{0, 1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        2, 3, 32'h300, 4'b0010, 1, 32'hA5A5A5A5, 32'h00009234, 0, 0, 0};
    vecs[9]  = '{0, 1, 3'b010, 32'h401, 32'h11111111, 32'h0,        1, 1, 32'h0,   4'b0000, 0, 32'h0,        32'h00009234, 0, 1, 0};
    vecs[10] = '{1, 0, 3'b001, 32'h203, 32'h0,        32'h0,        1, 1, 32'h0,   4'b0000, 0, 32'h0,        32'h00000000, 0, 1, 0};
    vecs[11] = '{1, 1, 3'b010, 32'h400, 32'hDEADBEEF, 32'h0,        1, 2, 32'h400, 4'b1111, 1, 32'hDEADBEEF, 32'h00000000, 0, 0, 0};
    vecs[12] = '{1, 0, 3'b011, 32'h500, 32'h0,        32'hCAFEF00D, 1, 2, 32'h500, 4'b1111, 0, 32'h0,        32'hCAFEF00D, 1, 0, 0};
    vecs[13] = '{1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1, 2, 32'h100, 4'b0010, 0, 32'h0,        32'h0000007F, 1, 0, 0};
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst stall", {31'h0, Stall_o}, 32'd0);
    chk("rst req", {31'h0, mem_req_o}, 32'd0);
    chk("rst we", {31'h0, mem_we_o}, 32'd0);
    chk("rst addr", mem_addr_o, 32'h0);
    chk("rst wdata", mem_wdata_o, 32'h0);
    chk("rst be", {28'h0, mem_be_o}, 32'h0);
    chk("rst rdata", rdata_o, 32'h0);
    chk("rst pulses", {29'h0, rdata_valid_o, misalign_o, err_o}, 32'h0);
    for (int i = 0; i < 14; i++) run(vecs[i], i);
`ifdef MEM_TIMEOUT_EN
    tv = '{1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 5, 32'h100, 4'b1111, 0, 32'h0, 32'h0, 0, 0, 1};
    run(tv, 100);
`endif
    @(negedge clk_i);
    MemRead_i = 1'b1; ALUResult_i = 32'h100; instr_i = {17'h0, 3'b010, 12'h003}; mem_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rstmid in_req", {31'h0, mem_req_o}, 32'd1);
    rst_i = 1'b1; MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rstmid req", {31'h0, mem_req_o}, 32'd0);
    chk("rstmid stall", {31'h0, Stall_o}, 32'd0);
    chk("rstmid pulses", {29'h0, rdata_valid_o, misalign_o, err_o}, 32'h0);
    @(negedge clk_i);
    #1;
    chk("rstmid pulses2", {29'h0, rdata_valid_o, misalign_o, err_o}, 32'h0);
    chk("rstmid rdata", rdata_o, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller on the consumer side of the EX/MEM pipeline register. It turns the latched MemRead/MemWrite, address (ALUResult) and store data (RDData) into a request/ready transaction on the data-memory port. While the access is outstanding it drives the Stall input of the front pipeline registers, including EX/MEM, and it returns lane-aligned, sign- or zero-extended load data to MEM/WB.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: REQ cycles without `mem_ready_i` before an access is aborted. Used only with MEM_TIMEOUT_EN.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- MemRead_i  in  1  load request held in EX/MEM.
- MemWrite_i  in  1  store request held in EX/MEM.
- ALUResult_i  in  32  byte address.
- RDData_i  in  32  store data; the operand sits in the low bits.
- instr_i  in  32  instruction; funct3 = instr_i[14:12].
- Stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word address {addr[31:2],2'b00}.
- mem_wdata_o  out  32  store data shifted into its lane(s).
- mem_be_o  out  4  byte enables.
- mem_ready_i  in  1  memory accepts or completes the request in this cycle.
- mem_rdata_i  in  32  read word; valid when mem_ready_i=1.
- rdata_o  out  32  extended load result for MEM/WB.
- rdata_valid_o  out  1  one-cycle pulse in DONE after a load.
- misalign_o  out  1  one-cycle pulse in DONE after a misaligned access.
- err_o  out  1  one-cycle pulse in DONE after a timeout.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - access = MemRead_i | MemWrite_i. If MemWrite_i is set, the access is a write, even when MemRead_i is also set.
  - On an aligned access: Stall_o=1 combinationally, latch address/we/be/wdata/funct3 into request registers, go to REQ.
  - On a misaligned access (half with addr[0]=1, word with addr[1:0]≠0): Stall_o=1, no request, set misalign flag, go to DONE.
- REQ:
  - mem_req_o=1 and Stall_o=1. Request fields stay constant from the registers until mem_ready_i.
  - On mem_ready_i: if the access is a read, latch the extended mem_rdata_i into rdata_o. Go to DONE.
- DONE:
  - Stall_o=0, no request. EX/MEM advances at this edge.
  - The same instruction is still visible on the inputs in this cycle and must not re-trigger an access.
  - Next state is IDLE unconditionally.
- Lanes (funct3):
  - 000/100 byte: be = 1<<addr[1:0].
  - 001/101 half: be = 0011 or 1100 by addr[1].
  - 010 word: be = 1111.
  - Store data is replicated or shifted to the selected lane.
- Load extension: 000 sign-extends a byte, 100 zero-extends a byte, 001 sign-extends a half, 101 zero-extends a half, 010 passes the word.
- Any other funct3 with an access: treat as word.
- rdata_o holds its value until the next completed load. A misaligned or aborted load writes 0 to rdata_o.
- Reset values:
  - State is IDLE.
  - Stall_o, mem_req_o, mem_we_o, rdata_valid_o, misalign_o and err_o are 0.
  - mem_addr_o, mem_wdata_o, rdata_o are 0; mem_be_o is 0000.
- Reset mid-transaction: abandon the request immediately, with no completion pulse.

## Timing
- The stall covers the detect cycle plus every REQ cycle. An access whose ready arrives after k cycles in REQ stalls for k+1 cycles; the minimum is 2.
- Stall_o is the only combinational output (it depends on state and access). All others are registered or decoded from state.
- mem_req_o rises the cycle after detection. It falls in the cycle after the mem_ready_i cycle.
- Non-memory instructions in IDLE keep Stall_o=0 with zero latency.
- Back-to-back accesses: DONE→IDLE→detect. There is always at least one Stall_o=0 cycle between two accesses.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8..16-bit counter, cleared on entering REQ, increments each REQ cycle.
  - When the counter reaches TIMEOUT_CYCLES without mem_ready_i, drop the request, pulse err_o in DONE, set rdata_o=0.
- MEM_TIMEOUT_EN undefined: no counter; REQ waits indefinitely and err_o is tied to 0.

## Structure
- Package mem_ctrl_pkg holds:
  - the state enum (IDLE/REQ/DONE);
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the default TIMEOUT_CYCLES.
- Sub-module mem_lane_align, purely combinational: byte-enable generation, store-data shifting and load extraction/extension. The FSM lives in mem_access_ctrl.

## Test plan
- LW at 0x100, ready on the 3rd REQ cycle, rdata 0x12345678 → Stall_o high 4 cycles, mem_addr_o=0x100, be=1111; rdata_o=0x12345678 with rdata_valid_o in DONE.
- LB at 0x103 with rdata 0x80FFFFFF → be=1000, rdata_o=0xFFFFFF80. LBU at the same address → rdata_o=0x00000080.
- SH at 0x202 with RDData 0x0000BEEF, ready immediately → mem_we_o=1, addr=0x200, be=1100, wdata[31:16]=0xBEEF; 2-cycle stall; no rdata_valid_o.
- LW at 0x101 → no mem_req_o, misalign_o pulses, rdata_o=0, Stall_o high exactly 1 cycle.
- rst_i asserted in the 2nd REQ cycle → next cycle IDLE, mem_req_o=0, Stall_o=0, no pulses.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and ready never asserted → err_o pulses after 4 REQ cycles, Stall_o drops in DONE.
